// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl: harness-side simulation run controller.
// Counts run cycles, enforces a cycle limit, gates waveform dumping to a
// cycle window, and folds per-channel done/fail reports into one verdict
// after a drain period.
// Optional macro TB_RUN_CTRL_AUTO_FINISH_EN: the block reports the verdict
// and heartbeats on stdout and ends the simulation itself.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | single cycle after reset release; configuration is latched
// S_RUN    | counting; watches timeout, channel fails, all-done
// S_DRAIN  | grace period before finishing; fail capture still live
// S_FINISH | terminal; verdict and counters held
module tb_run_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int CYC_W          = 32,
    parameter int DEF_MAX_CYCLES = 1000000,
    parameter int DRAIN_CYCLES   = 16,
    parameter int HB_PERIOD      = 10000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CYC_W-1:0]         cfg_max_cycles,
    input  logic                     cfg_dump_en,
    input  logic [CYC_W-1:0]         cfg_dump_start,
    input  logic [CYC_W-1:0]         cfg_dump_stop,
    input  logic [NUM_CH-1:0]        ch_done,
    input  logic [NUM_CH-1:0]        ch_fail,
    output logic [CYC_W-1:0]         cycle_cnt,
    output logic                     run_active,
    output logic                     dump_on,
    output logic                     heartbeat,
    output logic                     sim_finish,
    output logic                     sim_pass,
    output logic                     sim_timeout,
    output logic                     fail_valid,
    output logic [$clog2(NUM_CH):0]  fail_ch
);

    localparam int FCH_W = $clog2(NUM_CH) + 1;
    localparam int DRN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CYC_W-1:0]    max_lim;
    logic                dump_en_q;
    logic [CYC_W-1:0]    dump_start_q;
    logic [CYC_W-1:0]    dump_stop_q;
    logic [NUM_CH-1:0]   done_seen;
    logic [DRN_W-1:0]    drain_cnt;
    logic [CYC_W-1:0]    hb_left;

    logic [NUM_CH-1:0]   done_nxt;
    logic                fail_any;
    logic [FCH_W-1:0]    fail_idx;
    logic                counting;
    logic [CYC_W-1:0]    cnt_nxt;
    logic                timeout_hit;
    logic                fail_hit;
    logic                fail_valid_nxt;
    logic                timeout_nxt;
    logic                pass_nxt;
    logic                win_en;
    logic [CYC_W-1:0]    win_start;
    logic [CYC_W-1:0]    win_stop;
    logic                dump_nxt;
    logic                hb_fire;

    // Next-state and next-output decode; outputs are registered from these so
    // dump_on and heartbeat line up with the cycle_cnt value they describe.
    always_comb begin
        state_nxt = state;
        done_nxt  = done_seen | ch_done;
        fail_any  = |ch_fail;
        fail_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_fail[i]) fail_idx = FCH_W'(i);
        end
        counting    = (state == S_RUN) || (state == S_DRAIN);
        cnt_nxt     = (counting && (cycle_cnt != '1)) ? cycle_cnt + CYC_W'(1) : cycle_cnt;
        timeout_hit = (state == S_RUN) && (cycle_cnt == max_lim - CYC_W'(1));
        fail_hit    = counting && fail_any;

        case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN: begin
                if (timeout_hit)                  state_nxt = S_FINISH;
                else if (fail_any || (&done_nxt)) state_nxt = S_DRAIN;
                else                              state_nxt = S_RUN;
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nxt = S_FINISH;
            end
            default: state_nxt = S_FINISH;
        endcase

        fail_valid_nxt = fail_valid | fail_hit;
        timeout_nxt    = sim_timeout | timeout_hit;
        pass_nxt       = !fail_valid_nxt && !timeout_nxt && (&done_nxt);

        // In IDLE the window registers are being loaded this very edge.
        win_en    = (state == S_IDLE) ? cfg_dump_en    : dump_en_q;
        win_start = (state == S_IDLE) ? cfg_dump_start : dump_start_q;
        win_stop  = (state == S_IDLE) ? cfg_dump_stop  : dump_stop_q;
        dump_nxt  = ((state_nxt == S_RUN) || (state_nxt == S_DRAIN)) && win_en &&
                    (cnt_nxt >= win_start) && ((win_stop == '0) || (cnt_nxt < win_stop));

        // hb_left is the distance from cycle_cnt to the next multiple of HB_PERIOD.
        hb_fire = (HB_PERIOD != 0) && (state == S_RUN) && (state_nxt == S_RUN) &&
                  (hb_left == CYC_W'(1));
    end

    // Run FSM with configuration latch, drain/heartbeat down-counters and verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            max_lim      <= '0;
            dump_en_q    <= 1'b0;
            dump_start_q <= '0;
            dump_stop_q  <= '0;
            done_seen    <= '0;
            drain_cnt    <= '0;
            hb_left      <= '0;
            cycle_cnt    <= '0;
            run_active   <= 1'b0;
            dump_on      <= 1'b0;
            heartbeat    <= 1'b0;
            sim_finish   <= 1'b0;
            sim_pass     <= 1'b0;
            sim_timeout  <= 1'b0;
            fail_valid   <= 1'b0;
            fail_ch      <= '0;
        end else begin
            state      <= state_nxt;
            done_seen  <= done_nxt;
            cycle_cnt  <= cnt_nxt;
            run_active <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            dump_on    <= dump_nxt;
            heartbeat  <= hb_fire;

            if (state == S_IDLE) begin
                max_lim      <= (cfg_max_cycles == '0) ? CYC_W'(DEF_MAX_CYCLES) : cfg_max_cycles;
                dump_en_q    <= cfg_dump_en;
                dump_start_q <= cfg_dump_start;
                dump_stop_q  <= cfg_dump_stop;
                hb_left      <= CYC_W'(HB_PERIOD);
            end else if (hb_fire) begin
                hb_left <= CYC_W'(HB_PERIOD);
            end else if (state == S_RUN) begin
                hb_left <= hb_left - CYC_W'(1);
            end

            if ((state == S_RUN) && (state_nxt == S_DRAIN)) begin
                drain_cnt <= DRN_W'(DRAIN_CYCLES);
            end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRN_W'(1);
            end

            if (fail_hit && !fail_valid) fail_ch <= fail_idx;
            fail_valid  <= fail_valid_nxt;
            sim_timeout <= timeout_nxt;

            if ((state_nxt == S_FINISH) && (state != S_FINISH)) begin
                sim_finish <= 1'b1;
                sim_pass   <= pass_nxt;
            end
        end
    end

`ifdef TB_RUN_CTRL_AUTO_FINISH_EN
    logic finish_d;

    // Report the verdict on the rising edge of sim_finish, end the run one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_d <= 1'b0;
        end else begin
            finish_d <= sim_finish;
            if (heartbeat) $display("HEARTBEAT cyc=%0d", cycle_cnt);
            if (sim_finish && !finish_d) begin
                if (sim_pass)        $display("PASS");
                else if (fail_valid) $display("FAIL ch=%0d", fail_ch);
                else                 $display("TIMEOUT cyc=%0d", cycle_cnt);
            end
            if (finish_d) $finish;
        end
    end
`endif

endmodule
